uart_rx_os: RTL
===============

# uart_rx_os

Oversampling UART receiver: the receive end of the 8N1 serial link driven by the team's transmitter. It synchronizes the asynchronous `rx` line and detects the start edge. Each bit is recovered by 3-sample majority vote on a 16x baud tick. Each frame is reported as a one-cycle `o_rx_done` pulse with the byte, or as a `o_frame_err` pulse. It sits beside the transmitter under the UART controller and shares the controller's baud-rate generator, which must be configured for 16x bit rate.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first; no parity.
- `OVERSAMPLE`, 16: `b_tick` pulses per bit period; fixed at 16 for this revision.
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: reset, synchronous, active-high.
- `b_tick` input 1: one-clk pulse, `OVERSAMPLE` per bit period.
- `rx` input 1: asynchronous serial line; idle high.
- `o_dout` output `DATA_BITS`: last correctly framed byte; held until next good frame.
- `o_rx_done` output 1: one-clk pulse, byte valid on `o_dout`.
- `o_frame_err` output 1: one-clk pulse, stop bit sampled low.
- `o_rx_busy` output 1: high while state is not IDLE.

## Operation
- Input path:
  - 2-FF synchronizer on `rx`, both flops reset to 1.
  - A third flop holds the previous synced value for edge detection.
  - All logic uses the synced value `rxs`.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - Falling edge of `rxs` (prev 1, now 0) triggers the next clk: go to START, tick counter = 0, sample regs cleared.
  - The edge is clk-based, not tick-based.
- Tick counter:
  - 4 bits, increments only on `b_tick`.
  - Wraps 15 -> 0 at each bit boundary.
- Sampling:
  - On `b_tick` with counter = 7, 8, 9, capture `rxs`.
  - Bit value = majority of the 3 captures.
  - Evaluate on the `b_tick` where counter = 9.
- START:
  - At count-9 evaluation, majority 1 means false start: return to IDLE, no output pulse.
  - Otherwise stay until the `b_tick` at count 15, then go to DATA with bit index = 0.
- DATA:
  - Majority bit is shifted into the data register from the MSB side (LSB first on the wire) at count 9.
  - At the `b_tick` with count 15: if bit index = `DATA_BITS`-1, go to STOP; else increment the index.
- STOP:
  - At count-9 evaluation, majority 1: load `o_dout` from the shift register, pulse `o_rx_done`, go to IDLE.
  - Majority 0: pulse `o_frame_err`, leave `o_dout` unchanged, go to IDLE.
  - Early return at mid-stop allows back-to-back frames with no idle gap.
- Break / stuck-low line: no new rising-then-falling edge, so no restart; receiver stays IDLE.
- `b_tick` and the `rxs` edge in the same clk while in IDLE: the edge wins. The tick is not counted, and the counter starts at 0.

## Timing
- Reset values:
  - `o_dout` = 0, `o_rx_done` = 0, `o_frame_err` = 0, `o_rx_busy` = 0.
  - State IDLE, counters 0.
  - Synchronizer flops 1.
- Reset mid-frame: next clk in IDLE, `o_rx_busy` = 0. No done or error pulse for the aborted frame, and `o_dout` is cleared to 0.
- Input latency: `rx` fall to START entry is 3 clks (2 sync flops + edge register).
- Output latency:
  - `o_rx_done` / `o_frame_err` assert the clk after the STOP count-9 `b_tick`, for exactly 1 clk.
  - `o_dout` changes in that same clk.
  - `o_rx_busy` drops in that same clk.
- `o_rx_done` and `o_frame_err` are never high together.
- At most one pulse per detected start edge.
- Frame span from start edge to done: 9 bit periods + 10 ticks + sync latency.

## Test plan
- 0x55 at nominal rate (bench tick every 4 clks, bit = 64 clks) -> one `o_rx_done` pulse, `o_dout` = 0x55, `o_frame_err` = 0 throughout.
- 0xA5 then 0x3C, second start bit immediately after first stop bit -> two `o_rx_done` pulses, `o_dout` = 0xA5 then 0x3C.
- Glitch: `rx` low for 4 ticks, then high -> `o_rx_busy` high briefly, returns to 0 after the count-9 tick, no done or error pulse.
- Prior good byte 0x12, then frame 0xFF with stop bit = 0 -> one `o_frame_err` pulse, no `o_rx_done`, `o_dout` stays 0x12.
- Frame 0x00 with `rx` inverted only during tick 8 of bit 3 -> majority rejects the glitch, `o_dout` = 0x00, done pulse, no error.
- `rst` for 1 clk during data bit 4 -> `o_rx_busy` = 0 next clk, `o_dout` = 0, no pulses; the following frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: 8N1 oversampling UART receiver.
// Synchronizes rx, detects the start edge, recovers each bit by 3-sample
// majority vote on a 16x baud tick and reports each frame as a one-clk
// o_rx_done pulse (byte on o_dout) or an o_frame_err pulse.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   b_tick          - one-clk pulse, OVERSAMPLE per bit period
//   rx              - asynchronous serial line, idle high
//   o_dout          - last correctly framed byte, held until next good frame
//   o_rx_done       - one-clk pulse, byte valid on o_dout
//   o_frame_err     - one-clk pulse, stop bit sampled low
//   o_rx_busy       - high while a frame is in progress
module uart_rx_os #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] o_dout,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_rx_busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Sample points straddle mid-bit; evaluation happens on the last one.
    localparam logic [TICK_W-1:0] SAMP_A   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] SAMP_B   = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] SAMP_C   = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_sync_q, rx_sync_d;
    logic                 rx_prev_q, rx_prev_d;
    logic [1:0]           state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 samp_a_q, samp_a_d;
    logic                 samp_b_q, samp_b_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    logic rxs_c;
    logic fall_c;
    logic bit_c;

    // Next-state and output logic.
    always_comb begin
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
        rx_prev_d = rx_sync_q;
        state_d   = state_q;
        tick_d    = tick_q;
        idx_d     = idx_q;
        samp_a_d  = samp_a_q;
        samp_b_d  = samp_b_q;
        shreg_d   = shreg_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;

        rxs_c  = rx_sync_q;
        fall_c = rx_prev_q & ~rx_sync_q;
        // Third sample is the live synced value on the evaluation tick.
        bit_c  = (samp_a_q & samp_b_q) | (samp_a_q & rxs_c) | (samp_b_q & rxs_c);

        case (state_q)
            S_IDLE: begin
                // Edge is clk-based; a coincident b_tick is deliberately dropped.
                if (fall_c) begin
                    state_d  = S_START;
                    tick_d   = '0;
                    samp_a_d = 1'b0;
                    samp_b_d = 1'b0;
                end
            end
            default: begin
                if (b_tick) begin
                    tick_d = tick_q + TICK_W'(1);
                    if (tick_q == SAMP_A) samp_a_d = rxs_c;
                    if (tick_q == SAMP_B) samp_b_d = rxs_c;

                    if (tick_q == SAMP_C) begin
                        if (state_q == S_START) begin
                            if (bit_c) state_d = S_IDLE;
                        end else if (state_q == S_DATA) begin
                            shreg_d = {bit_c, shreg_q[DATA_BITS-1:1]};
                        end else begin
                            // Mid-stop return leaves room for a back-to-back start bit.
                            if (bit_c) begin
                                dout_d = shreg_q;
                                done_d = 1'b1;
                            end else begin
                                ferr_d = 1'b1;
                            end
                            state_d = S_IDLE;
                        end
                    end

                    if (tick_q == TICK_END) begin
                        if (state_q == S_START) begin
                            state_d = S_DATA;
                            idx_d   = '0;
                        end else if (state_q == S_DATA) begin
                            if (idx_q == IDX_LAST) state_d = S_STOP;
                            else                   idx_d   = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= S_IDLE;
            tick_q    <= '0;
            idx_q     <= '0;
            samp_a_q  <= 1'b0;
            samp_b_q  <= 1'b0;
            shreg_q   <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            rx_prev_q <= rx_prev_d;
            state_q   <= state_d;
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            samp_a_q  <= samp_a_d;
            samp_b_q  <= samp_b_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign o_dout      = dout_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;
    assign o_rx_busy   = busy_q;

endmodule
